// File: rtl/psi_lock_controller_if.sv
// Control/status bundle between the system control side and psi_lock_controller.
interface psi_lock_controller_if;
    logic       start;
    logic       abort;
    logic       psi;
    logic [7:0] set_period;
    logic [7:0] div_out;
    logic       busy;
    logic       locked;
    logic       fault;

    modport master (
        output start, abort, psi, set_period,
        input  div_out, busy, locked, fault
    );

    modport slave (
        input  start, abort, psi, set_period,
        output div_out, busy, locked, fault
    );
endinterface

// File: rtl/psi_lock_controller.sv
// Closed-loop PSI high-time regulator: measures each pulse and steps the divider
// load value until the width matches the latched target for LOCK_COUNT pulses.
module psi_lock_controller #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MAX_STEPS  = 255,
    parameter int unsigned INIT_DIV   = 127,
    parameter int unsigned TOL        = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    psi_lock_controller_if.slave   bus
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned MW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        TRACK  = 3'd2,
        LOCKED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t          state_q;
    logic            psi_q;
    logic [CW-1:0]   width_q;
    logic [DW-1:0]   tgt_q;
    logic [MW-1:0]   match_q;
    logic [DW-1:0]   steps_q;
    logic [DW-1:0]   div_q;
    logic            busy_q;
    logic            locked_q;
    logic            fault_q;

    logic            rise_c;
    logic            fall_c;
    logic            up_c;
    logic            in_tol_c;
    logic            sat_c;
    logic [31:0]     err_c;
    logic [DW-1:0]   div_adj_c;
    logic            lock_hit_c;
    logic            step_hit_c;

    // Edge detect and width compare against the latched target
    always_comb begin
        rise_c     = bus.psi & ~psi_q;
        fall_c     = ~bus.psi & psi_q;
        up_c       = 32'(width_q) > 32'(tgt_q);
        err_c      = up_c ? (32'(width_q) - 32'(tgt_q)) : (32'(tgt_q) - 32'(width_q));
        in_tol_c   = err_c <= TOL;
        sat_c      = up_c ? (div_q == {DW{1'b1}}) : (div_q == {DW{1'b0}});
        div_adj_c  = up_c ? (div_q + DW'(1)) : (div_q - DW'(1));
        lock_hit_c = (32'(match_q) + 32'd1) >= LOCK_COUNT;
        step_hit_c = (32'(steps_q) + 32'd1) >= MAX_STEPS;
    end

    // Pulse width counter, independent of state so a pulse begun in ARM is measured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psi_q   <= 1'b0;
            width_q <= '0;
        end else begin
            psi_q <= bus.psi;
            if (rise_c) begin
                width_q <= CW'(1);
            end else if (bus.psi && psi_q && (width_q != {CW{1'b1}})) begin
                width_q <= width_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            match_q  <= '0;
            steps_q  <= '0;
            div_q    <= DW'(INIT_DIV);
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FAULT: begin
                    if (bus.start) begin
                        state_q  <= ARM;
                        div_q    <= DW'(INIT_DIV);
                        tgt_q    <= bus.set_period;
                        match_q  <= '0;
                        steps_q  <= '0;
                        busy_q   <= 1'b1;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                end
                ARM: begin
                    if (rise_c) begin
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (fall_c) begin
                        if (in_tol_c) begin
                            match_q <= match_q + MW'(1);
                            if (lock_hit_c) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            match_q <= '0;
                            if (sat_c) begin
                                state_q <= FAULT;
                                busy_q  <= 1'b0;
                                fault_q <= 1'b1;
                            end else begin
                                div_q   <= div_adj_c;
                                steps_q <= steps_q + DW'(1);
                                if (step_hit_c) begin
                                    state_q <= FAULT;
                                    busy_q  <= 1'b0;
                                    fault_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (fall_c && !in_tol_c) begin
                        match_q  <= '0;
                        steps_q  <= '0;
                        locked_q <= 1'b0;
                        if (sat_c) begin
                            state_q <= FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            div_q   <= div_adj_c;
                            state_q <= TRACK;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    locked_q <= 1'b0;
                    fault_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_out = div_q;
    assign bus.busy    = busy_q;
    assign bus.locked  = locked_q;
    assign bus.fault   = fault_q;

endmodule

// File: tb/tb_psi_lock_controller.sv
// Directed bench for psi_lock_controller: three parameterisations share one stimulus,
// expected outputs are queued per step and compared one cycle after each falling edge.
module tb_psi_lock_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       psi;
    logic [7:0] set_period;

    int checks;
    int errors;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] div;
        logic       busy;
        logic       locked;
        logic       fault;
    } exp_t;

    exp_t sb[$];

    psi_lock_controller_if ifa ();
    psi_lock_controller_if ifb ();
    psi_lock_controller_if ifc ();

    assign ifa.start = start;  assign ifa.abort = abort;
    assign ifa.psi   = psi;    assign ifa.set_period = set_period;
    assign ifb.start = start;  assign ifb.abort = abort;
    assign ifb.psi   = psi;    assign ifb.set_period = set_period;
    assign ifc.start = start;  assign ifc.abort = abort;
    assign ifc.psi   = psi;    assign ifc.set_period = set_period;

    psi_lock_controller #(.LOCK_COUNT(4), .MAX_STEPS(255), .INIT_DIV(127), .TOL(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    psi_lock_controller #(.LOCK_COUNT(4), .MAX_STEPS(8), .INIT_DIV(127), .TOL(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    psi_lock_controller #(.LOCK_COUNT(4), .MAX_STEPS(255), .INIT_DIV(254), .TOL(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] div,
                        input logic busy, input logic locked, input logic fault);
        exp_t e;
        e.tag = tag; e.sel = sel; e.div = div;
        e.busy = busy; e.locked = locked; e.fault = fault;
        sb.push_back(e);
    endtask

    task automatic read_outs(input int sel, output logic [7:0] d, output logic b,
                             output logic l, output logic f);
        case (sel)
            0:       begin d = ifa.div_out; b = ifa.busy; l = ifa.locked; f = ifa.fault; end
            1:       begin d = ifb.div_out; b = ifb.busy; l = ifb.locked; f = ifb.fault; end
            default: begin d = ifc.div_out; b = ifc.busy; l = ifc.locked; f = ifc.fault; end
        endcase
    endtask

    // Pop every queued expectation and compare against the selected DUT
    task automatic drain();
        exp_t       e;
        logic [7:0] d;
        logic       b, l, f;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_outs(e.sel, d, b, l, f);
            chk({e.tag, ".div"},    d,          e.div);
            chk({e.tag, ".busy"},   8'(b),      8'(e.busy));
            chk({e.tag, ".locked"}, 8'(l),      8'(e.locked));
            chk({e.tag, ".fault"},  8'(f),      8'(e.fault));
        end
    endtask

    task automatic pulse(input int h);
        psi = 1'b1;
        repeat (h) @(negedge clk);
        psi = 1'b0;
        @(negedge clk);
        drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] p);
        set_period = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; psi = 1'b0; set_period = 8'd0;
        repeat (2) @(negedge clk);
        push("rst_a", 0, 8'd127, 1'b0, 1'b0, 1'b0);
        push("rst_b", 1, 8'd127, 1'b0, 1'b0, 1'b0);
        push("rst_c", 2, 8'd254, 1'b0, 1'b0, 1'b0);
        drain();
        rst = 1'b0;
        @(negedge clk);

        // Step direction
        do_start(8'd10);
        push("start_a", 0, 8'd127, 1'b1, 1'b0, 1'b0);
        drain();
        push("up1", 0, 8'd128, 1'b1, 1'b0, 1'b0);  pulse(12);
        push("up2", 0, 8'd129, 1'b1, 1'b0, 1'b0);  pulse(12);
        push("dn1", 0, 8'd128, 1'b1, 1'b0, 1'b0);  pulse(8);

        // Asynchronous reset mid-TRACK
        #2 rst = 1'b1;
        #1 push("rst_mid", 0, 8'd127, 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Lock acquisition and loss of lock
        do_start(8'd10);
        for (int i = 0; i < 3; i++) begin
            push("acq", 0, 8'd127, 1'b1, 1'b0, 1'b0);  pulse(10);
        end
        push("lock1", 0, 8'd127, 1'b1, 1'b1, 1'b0);   pulse(10);
        push("lost",  0, 8'd128, 1'b1, 1'b0, 1'b0);   pulse(11);
        for (int i = 0; i < 3; i++) begin
            push("reacq", 0, 8'd128, 1'b1, 1'b0, 1'b0); pulse(10);
        end
        push("lock2", 0, 8'd128, 1'b1, 1'b1, 1'b0);   pulse(10);

        // Timeout on dut_b, saturation on dut_c
        do_reset();
        do_start(8'd10);
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) push("tmo_step", 1, 8'(127 + k), 1'b1, 1'b0, 1'b0);
            else       push("tmo_fault", 1, 8'd135, 1'b0, 1'b0, 1'b1);
            if (k == 1)      push("sat_255", 2, 8'd255, 1'b1, 1'b0, 1'b0);
            else if (k == 2) push("sat_fault", 2, 8'd255, 1'b0, 1'b0, 1'b1);
            pulse(20);
        end
        push("fault_hold", 1, 8'd135, 1'b0, 1'b0, 1'b1);  pulse(20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        push("abort_b", 1, 8'd135, 1'b0, 1'b0, 1'b0);
        push("abort_c", 2, 8'd255, 1'b0, 1'b0, 1'b0);
        drain();

        // Start while busy ignored; start+abort together returns to idle
        do_reset();
        do_start(8'd10);
        push("trk", 0, 8'd128, 1'b1, 1'b0, 1'b0);  pulse(12);
        do_start(8'd50);
        push("ign_start", 0, 8'd129, 1'b1, 1'b0, 1'b0);  pulse(12);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        push("start_abort", 0, 8'd129, 1'b0, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        push("idle_hold", 0, 8'd129, 1'b0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psi_lock_controller.md
# psi_lock_controller

Closed-loop sequencer for the PSI pulse-width regulation loop. It latches a target high-time, measures each PSI high pulse in clk cycles, and steps the divider setting that generates PSI until the measured width matches the target for a programmable number of consecutive pulses. It reports lock, detects loss of lock, and flags faults on timeout or divider saturation. It sits between the system control interface and the PSI divider, and its `div_out` drives the divider's load value.

## Interface
- LOCK_COUNT, default 4: consecutive in-tolerance pulses required for lock (1..15).
- MAX_STEPS, default 255: divider adjustments allowed per acquisition before fault (1..255).
- INIT_DIV, default 127: divider value loaded at reset and on start.
- TOL, default 0: allowed absolute width error in clk cycles.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin acquisition.
- abort  in  1  single-cycle request to stop and return to idle.
- psi  in  1  regulated pulse, synchronous to clk.
- set_period  in  8  target high-time in clk cycles; latched on accepted start.
- div_out  out  8  divider setting.
- busy  out  1  high in ARM, TRACK and LOCKED.
- locked  out  1  high in LOCKED.
- fault  out  1  high in FAULT.

## Operation
- Edge detection: `psi_d` is the registered `psi`. A rising edge is `psi & ~psi_d`; a falling edge is `~psi & psi_d`.
- Width counter (16 bit): loads 1 on a rising edge and increments while `psi & psi_d`. It saturates at 0xFFFF. On a falling edge the measured width `w` equals the counter, so a pulse high for H sampled cycles gives `w` = H.
- Compare: `tgt` is the zero-extended latched `set_period`. A pulse is in tolerance when |w − tgt| ≤ TOL.
- Adjust rule: if `w` > `tgt`, `div_out` +1; if `w` < `tgt`, `div_out` −1. There is no wrap.
- Saturation: an adjustment required with `div_out` already at 255 (increment) or 0 (decrement) goes to FAULT with `div_out` unchanged.
- State IDLE: outputs low, `div_out` held. On start, load `div_out` with INIT_DIV, latch `set_period`, clear steps and match count, and go to ARM.
- State ARM: discards any partial pulse. The first rising edge moves to TRACK.
- State TRACK, on each falling edge:
  - In tolerance: match +1. When match reaches LOCK_COUNT, go to LOCKED.
  - Out of tolerance: match ← 0, apply the adjust rule, steps +1. When steps reaches MAX_STEPS, go to FAULT; the final adjustment is still applied.
- State LOCKED, on each falling edge:
  - In tolerance: no action.
  - Out of tolerance: match ← 0, steps ← 0, apply the adjust rule, go to TRACK.
- State FAULT: `fault` high, `div_out` held. Start re-enters acquisition as from IDLE. Abort goes to IDLE.
- Abort in any state goes to IDLE with `div_out` held. When start and abort arrive in the same cycle, abort wins.
- Start outside IDLE and FAULT is ignored. `set_period` changes while busy are ignored.

## Timing
- Reset values: `div_out` = INIT_DIV, `busy` = 0, `locked` = 0, `fault` = 0. State is IDLE and all counters are 0. Reset asserted mid-operation forces these values immediately.
- start registered at edge N: `busy` = 1 and `div_out` = INIT_DIV from edge N+1.
- Falling-edge cycle F: `div_out`, `locked`, `fault` and the state update at the clock edge ending cycle F and are visible in cycle F+1.
- A pulse whose rising edge is seen in ARM is measured normally.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst mid-TRACK → `div_out` = 127, `busy` = 0, `locked` = 0, `fault` = 0 in the same cycle.
- Step direction: start with `set_period` = 10, then pulses high 12 cycles / low 5 cycles → `div_out` 128, then 129, each one cycle after the falling edge. Then pulses high 8 cycles → `div_out` decrements.
- Lock acquisition (LOCK_COUNT = 4): `set_period` = 10, four pulses high 10 cycles → `locked` = 1 one cycle after the 4th falling edge, with `div_out` unchanged throughout.
- Loss of lock: from LOCKED, one pulse high 11 cycles → `locked` = 0 and `div_out` +1 in the next cycle, state TRACK. Then four 10-cycle pulses → locked again.
- Timeout (MAX_STEPS = 8): `set_period` = 10 with continuous 20-cycle pulses → `fault` = 1 after the 8th falling edge in TRACK, `div_out` = 135, `busy` = 0.
- Saturation and abort:
  - INIT_DIV = 254 with 20-cycle pulses → `div_out` = 255, then `fault` on the next falling edge with `div_out` = 255.
  - Abort in FAULT → IDLE with `fault` = 0.
  - Simultaneous start and abort in TRACK → IDLE.
